c1_n: RTL and testbench

C1_N -- requirements
Module: c1_n

---
 rtl/c1_n.sv | 91 +++++++++
 tb/tb_c1_n.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/c1_n.sv
// c1_n: up/down modulo-MODULUS counter with synchronous parallel load and
// a registered terminal-count pulse.
// Optional feature macro: C1_N_SATURATE_EN. When it is defined the counter
// holds at its limits instead of wrapping. When it is undefined the counter
// wraps modulo MODULUS.

module c1_n #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             reverse,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_min;

    assign at_max = (Q == CNT_MAX);
    assign at_min = (Q == '0);

    // Out-of-range load values clamp to the top of the count range.
    always_comb begin
        load_clamped = load_value;
        if (32'(load_value) >= MODULUS) begin
            load_clamped = CNT_MAX;
        end
    end

    // Next count and terminal-count flag.
    // Priority is load, then enable, then hold.
    // tc is set on any enabled step that starts at the limit for the current direction.
    always_comb begin
        q_nxt  = Q;
        tc_nxt = 1'b0;
        if (load) begin
            q_nxt = load_clamped;
        end else if (enable) begin
            if (!reverse) begin
                if (at_max) begin
                    tc_nxt = 1'b1;
`ifdef C1_N_SATURATE_EN
                    q_nxt  = Q;
`else
                    q_nxt  = '0;
`endif
                end else begin
                    q_nxt = Q + CNT_ONE;
                end
            end else begin
                if (at_min) begin
                    tc_nxt = 1'b1;
`ifdef C1_N_SATURATE_EN
                    q_nxt  = Q;
`else
                    q_nxt  = CNT_MAX;
`endif
                end else begin
                    q_nxt = Q - CNT_ONE;
                end
            end
        end
    end

    // Count and tc registers; reset clears both asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q  <= '0;
            tc <= 1'b0;
        end else begin
            Q  <= q_nxt;
            tc <= tc_nxt;
        end
    end

    // Zero flag follows the count without a register stage.
    assign zero = (Q == '0);

endmodule

// File: tb/tb_c1_n.sv
// Directed bench for c1_n: a vector table for the MODULUS=10 counter, plus
// hand-written sequences for reset timing and for MODULUS=2^WIDTH overflow.

module tb_c1_n;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       reverse;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] q10;
    logic       tc10;
    logic       zero10;
    logic [3:0] q16;
    logic       tc16;
    logic       zero16;

    int passed = 0;
    int total  = 0;

    c1_n #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .reset(reset), .enable(enable), .reverse(reverse),
        .load(load), .load_value(load_value), .Q(q10), .tc(tc10), .zero(zero10)
    );

    c1_n #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .reset(reset), .enable(enable), .reverse(reverse),
        .load(load), .load_value(load_value), .Q(q16), .tc(tc16), .zero(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       rev;
        logic       ld;
        logic [3:0] lv;
        logic [3:0] q;
        logic       tc;
        logic       z;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic rev, input logic ld,
                                input logic [3:0] lv, input logic [3:0] q,
                                input logic tc, input logic z);
        vec_t v;
        v.en = en; v.rev = rev; v.ld = ld; v.lv = lv;
        v.q = q; v.tc = tc; v.z = z;
        return v;
    endfunction

    task automatic chk10(input string name, input logic [3:0] eq, input logic etc, input logic ez);
        total++;
        if (q10 === eq && tc10 === etc && zero10 === ez) begin
            passed++;
        end else begin
            $display("FAIL %s: got Q=%0d tc=%b zero=%b, expected Q=%0d tc=%b zero=%b",
                     name, q10, tc10, zero10, eq, etc, ez);
        end
    endtask

    task automatic chk16(input string name, input logic [3:0] eq, input logic etc, input logic ez);
        total++;
        if (q16 === eq && tc16 === etc && zero16 === ez) begin
            passed++;
        end else begin
            $display("FAIL %s: got Q=%0d tc=%b zero=%b, expected Q=%0d tc=%b zero=%b",
                     name, q16, tc16, zero16, eq, etc, ez);
        end
    endtask

    // Drive inputs, then sample 1 time unit after the next rising edge.
    task automatic step(input logic en, input logic rev, input logic ld, input logic [3:0] lv);
        enable = en; reverse = rev; load = ld; load_value = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; reverse = 1'b0; load = 1'b0; load_value = 4'd0;
        #12;
        chk10("reset_state", 4'd0, 1'b0, 1'b1);
        chk16("reset_state16", 4'd0, 1'b0, 1'b1);
        #1 reset = 1'b1;

        // Up count over 12 edges: 1..9, wrap to 0 with tc, then 1, 2.
        for (int i = 1; i <= 9; i++) vecs.push_back(mk(1, 0, 0, 0, 4'(i), 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 4'd1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd2, 0, 0));
        // Hold.
        vecs.push_back(mk(0, 0, 0, 0, 4'd2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd2, 0, 0));
        // Down count through the 0 -> 9 wrap.
        vecs.push_back(mk(1, 1, 0, 0, 4'd1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 4'd9, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd8, 0, 0));
        // Loads: clamping, priority over enable, and no tc on a load.
        vecs.push_back(mk(0, 0, 1, 4'd12, 4'd9, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'd12, 4'd9, 0, 0));
        vecs.push_back(mk(1, 1, 1, 4'd0, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 4'd0, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'd9, 4'd9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd15, 4'd9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd10, 4'd9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd5, 4'd5, 0, 0));
        // Reverse toggled every cycle starting from 5.
        vecs.push_back(mk(1, 0, 0, 0, 4'd6, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd6, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd3, 4'd3, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].rev, vecs[i].ld, vecs[i].lv);
            chk10($sformatf("vec%0d", i), vecs[i].q, vecs[i].tc, vecs[i].z);
        end

        // First step down after reset goes straight to 9 and pulses tc once.
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        enable = 1'b0; load = 1'b0;
        @(negedge clk);
        chk10("down_from_reset_pre", 4'd0, 1'b0, 1'b1);
        step(1, 1, 0, 0);
        chk10("down_from_reset", 4'd9, 1'b1, 1'b0);
        step(0, 1, 0, 0);
        chk10("down_from_reset_tc_drop", 4'd9, 1'b0, 1'b0);

        // Asynchronous reset between edges while Q = 7.
        step(0, 0, 1, 4'd7);
        chk10("load7", 4'd7, 1'b0, 1'b0);
        load = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk10("async_reset_q7", 4'd0, 1'b0, 1'b1);

        // Asynchronous reset must also clear a pending tc.
        reset = 1'b1;
        step(1, 1, 0, 0);
        chk10("tc_before_reset", 4'd9, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk10("async_reset_tc", 4'd0, 1'b0, 1'b1);

        // A load requested while reset is held is discarded.
        enable = 1'b1; reverse = 1'b0; load = 1'b1; load_value = 4'd5;
        @(posedge clk);
        #1;
        chk10("load_during_reset", 4'd0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        step(1, 0, 0, 0);
        chk10("first_edge_after_reset", 4'd1, 1'b0, 1'b0);

        // MODULUS = 2^WIDTH: 15 -> 0 is plain binary overflow.
        step(0, 0, 1, 4'd14);
        chk16("m16_load14", 4'd14, 1'b0, 1'b0);
        step(1, 0, 0, 0);
        chk16("m16_to15", 4'd15, 1'b0, 1'b0);
`ifdef C1_N_SATURATE_EN
        step(1, 0, 0, 0);
        chk16("m16_sat1", 4'd15, 1'b1, 1'b0);
        step(1, 0, 0, 0);
        chk16("m16_sat2", 4'd15, 1'b1, 1'b0);
        step(1, 0, 0, 0);
        chk16("m16_sat3", 4'd15, 1'b1, 1'b0);
`else
        step(1, 0, 0, 0);
        chk16("m16_wrap", 4'd0, 1'b1, 1'b1);
        step(1, 0, 0, 0);
        chk16("m16_after_wrap", 4'd1, 1'b0, 1'b0);
        step(1, 1, 0, 0);
        chk16("m16_down", 4'd0, 1'b0, 1'b1);
        step(1, 1, 0, 0);
        chk16("m16_underflow", 4'd15, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
